rsa_job_dispatcher: RTL and testbench

Synthesizable initiator for the RSACypher_sc operand/result interface. It accepts RSA jobs (base, exponent, modulus plus security labels) from an upstream valid/ready port and buffers them in a small FIFO. It launches each job on the cypher core with a one-cycle ds pulse, captures cypher and cypher_label when the core returns ready, and presents each result downstream together with its measured latency. It replaces the behavioural stimulus loop whenever the core is embedded in a system.

---
 rtl/rsa_job_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_rsa_job_dispatcher.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_dispatcher.sv
// rsa_job_dispatcher: buffers RSA jobs in a small FIFO, launches them one at a
// time on the RSACypher core with a one-cycle ds strobe, captures the result
// and its secrecy label, and presents it downstream with the measured latency.
//
// Handshakes: both job_* (upstream) and res_* (downstream) are strict
// valid/ready. A transfer happens on a rising clk edge where valid and ready
// are both 1. A valid, once raised, holds its payload stable until the
// transfer. ready may depend on internal state only, never on valid.
module rsa_job_dispatcher #(
  parameter int KEYSIZE    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LATW       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [KEYSIZE-1:0] job_base,
  input  logic [KEYSIZE-1:0] job_exp,
  input  logic [KEYSIZE-1:0] job_mod,
  input  logic               job_base_label,
  input  logic               job_exp_label,
  input  logic               job_mod_label,
  output logic [KEYSIZE-1:0] indata,
  output logic [KEYSIZE-1:0] inExp,
  output logic [KEYSIZE-1:0] inMod,
  output logic               indata_label,
  output logic               inExp_label,
  output logic               inMod_label,
  output logic               ds,
  input  logic               ready,
  input  logic [KEYSIZE-1:0] cypher,
  input  logic               cypher_label,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [KEYSIZE-1:0] res_data,
  output logic               res_label,
  output logic [LATW-1:0]    res_latency,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    HOLD      = 3'd4
  } state_t;

  typedef struct packed {
    logic [KEYSIZE-1:0] base;
    logic [KEYSIZE-1:0] expo;
    logic [KEYSIZE-1:0] modu;
    logic               base_label;
    logic               exp_label;
    logic               mod_label;
  } job_t;

  state_t             state, next_state;
  job_t               mem [FIFO_DEPTH];
  job_t               head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               empty, full, push, pop, launching;
  logic [KEYSIZE-1:0] base_q, exp_q, mod_q;
  logic               base_label_q, exp_label_q, mod_label_q;
  logic               job_secret;
  logic [LATW-1:0]    lat_cnt;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign job_ready = !full;
  assign push      = job_valid && job_ready;
  assign launching = (state == LAUNCH);
  assign pop       = launching;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;
  assign state_dbg = state;

  // During the launch cycle the core sees the FIFO head directly; afterwards
  // it sees the registered copy, which stays put until the next launch.
  assign indata       = launching ? head.base       : base_q;
  assign inExp        = launching ? head.expo       : exp_q;
  assign inMod        = launching ? head.modu       : mod_q;
  assign indata_label = launching ? head.base_label : base_label_q;
  assign inExp_label  = launching ? head.exp_label  : exp_label_q;
  assign inMod_label  = launching ? head.mod_label  : mod_label_q;

  // Job storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{job_base, job_exp, job_mod,
                       job_base_label, job_exp_label, job_mod_label};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the start strobe; a result must be accepted
  // before the next launch, and a stray ready while idle with no job is ignored.
  always_comb begin
    next_state = state;
    ds         = 1'b0;
    case (state)
      IDLE:      if (!empty && ready) next_state = LAUNCH;
      LAUNCH: begin
        ds         = 1'b1;
        next_state = WAIT_LOW;
      end
      WAIT_LOW:  if (!ready) next_state = WAIT_HIGH;
      WAIT_HIGH: if (ready) next_state = HOLD;
      HOLD:      if (res_ready) next_state = (!empty && ready) ? LAUNCH : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Operand copies, latency counter and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q       <= '0;
      exp_q        <= '0;
      mod_q        <= '0;
      base_label_q <= 1'b1;
      exp_label_q  <= 1'b1;
      mod_label_q  <= 1'b1;
      job_secret   <= 1'b0;
      lat_cnt      <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_label    <= 1'b0;
      res_latency  <= '0;
    end else begin
      case (state)
        LAUNCH: begin
          base_q       <= head.base;
          exp_q        <= head.expo;
          mod_q        <= head.modu;
          base_label_q <= head.base_label;
          exp_label_q  <= head.exp_label;
          mod_label_q  <= head.mod_label;
          job_secret   <= head.base_label | head.exp_label | head.mod_label;
          lat_cnt      <= LATW'(1);
        end
        WAIT_LOW: begin
          if (lat_cnt != '1) lat_cnt <= lat_cnt + LATW'(1);
        end
        WAIT_HIGH: begin
          if (lat_cnt != '1) lat_cnt <= lat_cnt + LATW'(1);
          if (ready) begin
            res_data    <= cypher;
            // Never declassify: any secret operand forces a secret result.
            res_label   <= cypher_label | job_secret;
            res_latency <= lat_cnt;
            res_valid   <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_dispatcher.sv
// Directed bench for rsa_job_dispatcher with a behavioural RSACypher core model.
module tb_rsa_job_dispatcher;

  localparam int K    = 32;
  localparam int LATW = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           job_valid, job_ready;
  logic [K-1:0]   job_base, job_exp, job_mod;
  logic           job_base_label, job_exp_label, job_mod_label;
  logic [K-1:0]   indata, inExp, inMod;
  logic           indata_label, inExp_label, inMod_label;
  logic           ds, ready;
  logic [K-1:0]   cypher;
  logic           cypher_label;
  logic           res_valid, res_ready;
  logic [K-1:0]   res_data;
  logic           res_label;
  logic [LATW-1:0] res_latency;
  logic           busy;
  logic [2:0]     state_dbg;

  rsa_job_dispatcher #(.KEYSIZE(K), .FIFO_DEPTH(4), .LATW(LATW)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_exp(job_exp), .job_mod(job_mod),
    .job_base_label(job_base_label), .job_exp_label(job_exp_label),
    .job_mod_label(job_mod_label),
    .indata(indata), .inExp(inExp), .inMod(inMod),
    .indata_label(indata_label), .inExp_label(inExp_label), .inMod_label(inMod_label),
    .ds(ds), .ready(ready), .cypher(cypher), .cypher_label(cypher_label),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_label(res_label), .res_latency(res_latency),
    .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [LATW+K:0] exp_q[$];

  // Reference modexp, left-to-right square-and-multiply.
  function automatic logic [K-1:0] ref_modexp(input logic [K-1:0] b, input logic [K-1:0] e,
                                               input logic [K-1:0] m);
    logic [63:0] r, bb, mm;
    mm = {32'b0, m};
    bb = {32'b0, b};
    r  = 64'd1 % mm;
    for (int i = K - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[K-1:0];
  endfunction

  // Core model arithmetic, right-to-left variant.
  function automatic logic [K-1:0] core_modexp(input logic [K-1:0] b, input logic [K-1:0] e,
                                                input logic [K-1:0] m);
    logic [63:0] r, bb, mm;
    mm = {32'b0, m};
    r  = 64'd1 % mm;
    bb = {32'b0, b} % mm;
    for (int i = 0; i < K; i++) begin
      if (e[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return r[K-1:0];
  endfunction

  // Core model: after a ds edge, ready is low and returns high core_lat cycles
  // after the ds cycle. stall forces ready low to emulate a busy core.
  logic         core_ready;
  logic [K-1:0] core_cypher;
  int           core_left;
  int           core_lat;
  logic         model_label;
  logic         stall;
  assign ready        = core_ready & ~stall;
  assign cypher       = core_cypher;
  assign cypher_label = model_label;

  always @(posedge clk) begin
    if (!reset) begin
      core_ready  <= 1'b1;
      core_left   <= 0;
      core_cypher <= '0;
    end else if (ds && core_ready) begin
      core_ready  <= 1'b0;
      core_left   <= core_lat - 1;
      core_cypher <= core_modexp(indata, inExp, inMod);
    end else if (!core_ready) begin
      if (core_left <= 1) core_ready <= 1'b1;
      core_left <= core_left - 1;
    end
  end

  // Launch bookkeeping: ds count, back-to-back ds, launch with result outstanding.
  int ds_count = 0;
  int ds_double = 0;
  int early_launch = 0;
  int outstanding = 0;
  logic ds_prev = 1'b0;
  always @(posedge clk) begin
    if (!reset) begin
      outstanding <= 0;
      ds_prev     <= 1'b0;
    end else begin
      if (ds) ds_count <= ds_count + 1;
      if (ds && ds_prev) ds_double <= ds_double + 1;
      if (ds && outstanding != 0) early_launch <= early_launch + 1;
      outstanding <= outstanding + (ds ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
      ds_prev <= ds;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: present one job and hold it until accepted.
  task automatic push_job(input logic [K-1:0] b, input logic [K-1:0] e, input logic [K-1:0] m,
                          input logic bl, input logic el, input logic ml);
    int n = 0;
    job_base = b; job_exp = e; job_mod = m;
    job_base_label = bl; job_exp_label = el; job_mod_label = ml;
    job_valid = 1'b1;
    while (!job_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(job_ready), 64'(1));
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  // Wait for a result, compare it, then accept it after rdly cycles.
  task automatic collect(input string tag, input logic [K-1:0] ed, input logic el,
                         input logic [LATW-1:0] elat, input int rdly);
    int n = 0;
    while (!res_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(res_valid), 64'(1));
    check({tag, "_data"}, 64'(res_data), 64'(ed));
    check({tag, "_label"}, 64'(res_label), 64'(el));
    check({tag, "_latency"}, 64'(res_latency), 64'(elat));
    repeat (rdly) @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    logic [K-1:0]    snap_data;
    logic            snap_label;
    logic [LATW-1:0] snap_lat;
    logic [LATW+K:0] item;
    int n;

    reset = 1'b0; job_valid = 1'b0; res_ready = 1'b0; stall = 1'b0;
    core_lat = 10; model_label = 1'b0;
    job_base = '0; job_exp = '0; job_mod = '0;
    job_base_label = 1'b0; job_exp_label = 1'b0; job_mod_label = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ds", 64'(ds), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_job_ready", 64'(job_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_label", 64'(res_label), 64'(0));
    check("rst_res_latency", 64'(res_latency), 64'(0));
    check("rst_indata", 64'({indata, inExp, inMod}), 64'(0));
    check("rst_op_labels", 64'({indata_label, inExp_label, inMod_label}), 64'(3'b111));
    check("rst_state", 64'(state_dbg), 64'(0));
    reset = 1'b1;

    // ready high with nothing queued: nothing launches or is captured
    repeat (5) @(negedge clk);
    check("idle_no_capture", 64'(res_valid), 64'(0));
    check("idle_no_ds", 64'(ds_count), 64'(0));

    // Single job 5^3 mod 13 = 8, latency 10
    core_lat = 10;
    push_job(32'd5, 32'd3, 32'd13, 1'b0, 1'b0, 1'b0);
    collect("single", 32'd8, 1'b0, 16'd10, 3);
    @(negedge clk);
    check("single_ds_count", 64'(ds_count), 64'(1));
    check("single_ops_held", 64'({indata, inExp}), {32'd5, 32'd3});
    check("single_mod_held", 64'(inMod), 64'(13));
    check("single_busy_after", 64'(busy), 64'(0));

    // Secret exponent: 2^10 mod 1000 = 24, label forced to 1
    core_lat = 4;
    push_job(32'd2, 32'd10, 32'd1000, 1'b0, 1'b1, 1'b0);
    collect("label_exp", 32'd24, 1'b1, 16'd4, 0);

    // Core-reported secret passes through: 5^2 mod 7 = 4
    model_label = 1'b1;
    push_job(32'd5, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0);
    collect("label_core", 32'd4, 1'b1, 16'd4, 0);
    model_label = 1'b0;

    // Zero exponent, shortest core latency: 7^0 mod 11 = 1
    core_lat = 2;
    push_job(32'd7, 32'd0, 32'd11, 1'b0, 1'b0, 1'b0);
    collect("exp_zero", 32'd1, 1'b0, 16'd2, 0);

    // Fill with core busy: 4 entries fill the FIFO, 5th waits for the first pop
    core_lat = 8;
    stall = 1'b1;
    @(negedge clk);
    dc0 = ds_count;
    push_job(32'd2, 32'd5, 32'd31, 1'b0, 1'b0, 1'b0);
    push_job(32'd3, 32'd3, 32'd10, 1'b0, 1'b0, 1'b0);
    push_job(32'd4, 32'd2, 32'd9, 1'b0, 1'b0, 1'b0);
    check("fill_ready_after3", 64'(job_ready), 64'(1));
    push_job(32'd6, 32'd2, 32'd35, 1'b0, 1'b0, 1'b0);
    fork
      push_job(32'd9, 32'd2, 32'd50, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        check("fill_full_ready", 64'(job_ready), 64'(0));
        check("fill_busy", 64'(busy), 64'(1));
        check("fill_no_launch", 64'(ds_count), 64'(dc0));
        stall = 1'b0;
      end
    join
    check("fill_one_launch", 64'(ds_count), 64'(dc0 + 1));
    collect("fill0", 32'd1, 1'b0, 16'd8, 0);
    collect("fill1", 32'd7, 1'b0, 16'd8, 1);
    collect("fill2", 32'd7, 1'b0, 16'd8, 0);
    collect("fill3", 32'd1, 1'b0, 16'd8, 2);
    collect("fill4", 32'd31, 1'b0, 16'd8, 0);

    // Backpressure: 3^5 mod 17 = 5 held 20 cycles with another job queued
    core_lat = 4;
    push_job(32'd3, 32'd5, 32'd17, 1'b0, 1'b0, 1'b0);
    push_job(32'd10, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 64'(res_valid), 64'(1));
    check("bp_data", 64'(res_data), 64'(5));
    snap_data = res_data; snap_label = res_label; snap_lat = res_latency;
    dc0 = ds_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_stable", 64'({res_valid, res_data, res_label, res_latency, ds}),
            64'({1'b1, snap_data, snap_label, snap_lat, 1'b0}));
    end
    check("bp_no_second_ds", 64'(ds_count), 64'(dc0));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("bp_ds_after_accept", 64'(ds), 64'(1));
    check("bp_valid_dropped", 64'(res_valid), 64'(0));
    collect("bp_next", 32'd2, 1'b0, 16'd4, 0);

    // Pipeline of 100 random jobs against the reference modexp
    core_lat = 3;
    @(negedge clk);
    dc0 = ds_count;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [K-1:0] b, e, m;
          logic bl, el, ml;
          b = $urandom(); e = $urandom(); m = $urandom();
          if (m == '0) m = 32'd1;
          bl = ($urandom_range(0, 3) == 0);
          el = ($urandom_range(0, 3) == 0);
          ml = ($urandom_range(0, 3) == 0);
          exp_q.push_back({16'd3, bl | el | ml, ref_modexp(b, e, m)});
          push_job(b, e, m, bl, el, ml);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          int w = 0;
          while (!res_valid && w < 1000) begin
            @(negedge clk);
            w++;
          end
          check("rand_queue_nonempty", 64'(exp_q.size() > 0), 64'(1));
          item = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          collect("rand", item[K-1:0], item[K], item[LATW+K:K+1], $urandom_range(0, 2));
        end
      end
    join
    @(negedge clk);
    check("rand_ds_count", 64'(ds_count), 64'(dc0 + 100));
    check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset while in WAIT_HIGH with another job queued
    core_lat = 20;
    push_job(32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
    push_job(32'd5, 32'd1, 32'd9, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (state_dbg != 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_wait_high", 64'(state_dbg), 64'(3));
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ds", 64'(ds), 64'(0));
    check("mid_rst_valid", 64'(res_valid), 64'(0));
    check("mid_rst_job_ready", 64'(job_ready), 64'(1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    core_lat = 6;
    push_job(32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
    collect("post_rst", 32'd4, 1'b0, 16'd6, 0);

    // Global launch discipline
    @(negedge clk);
    check("ds_never_double", 64'(ds_double), 64'(0));
    check("no_early_launch", 64'(early_launch), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
